nn_layer_sequencer: RTL

Control stage directly upstream of the NN datapath (weight ROM, weight/bias register, ALU, input mux). The block replaces hand-driven layer stepping: on `start` it walks `layer_no` through every layer, with one-cycle weight prefetch ahead of the ALU. It drives ALU `enable` and the input-mux `select_line` (0 = external input, 1 = ALU feedback). It then captures the final ALU output into a result register and signals `done`.

---
 rtl/nn_layer_sequencer.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/nn_layer_sequencer.sv
// Layer sequencer for the NN datapath: prefetch, one RUN cycle per layer, drain and capture.
// Define NN_SEQ_ARGMAX_EN to add a lane-serial signed argmax over the captured result.
module nn_layer_sequencer #(
    parameter int NUM_LAYERS = 4,
    parameter int LANES      = 6,
    parameter int LANE_W     = 64,
    parameter int DATA_W     = LANES * LANE_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [1:0]        layer_no,
    output logic              enable,
    output logic              select_line,
    input  logic [DATA_W-1:0] alu_output_data,
    output logic [DATA_W-1:0] result_data,
    output logic [2:0]        result_class
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFETCH,
        S_RUN,
        S_DRAIN
`ifdef NN_SEQ_ARGMAX_EN
        , S_ARGMAX
`endif
    } state_e;

    localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);
    localparam logic       LAST_SEL   = 1'(NUM_LAYERS > 1);

    state_e              state_q, state_d;
    logic [1:0]          idx_q, idx_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   result_q;
    logic                capture;

`ifdef NN_SEQ_ARGMAX_EN
    logic [2:0]               lane_q, lane_d;
    logic [2:0]               best_q, best_d;
    logic [2:0]               class_q, class_d;
    logic signed [LANE_W-1:0] max_q, max_d;
    logic signed [LANE_W-1:0] lane_val;
    logic                     take;

    assign lane_val = $signed(result_q[int'(lane_q) * LANE_W +: LANE_W]);
    // Lane 0 seeds the running maximum; strictly-greater keeps ties on the lowest lane.
    assign take     = (lane_q == 3'd0) || (lane_val > max_q);
    assign result_class = class_q;
`else
    assign result_class = 3'd0;
`endif

    // NOTE: every combinational output gets a default before the case so no path leaves a latch.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        done_d      = 1'b0;
        capture     = 1'b0;
        busy        = 1'b0;
        enable      = 1'b0;
        select_line = 1'b0;
        layer_no    = 2'd0;
`ifdef NN_SEQ_ARGMAX_EN
        lane_d  = lane_q;
        best_d  = best_q;
        max_d   = max_q;
        class_d = class_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_PREFETCH;
            end
            S_PREFETCH: begin
                busy    = 1'b1;
                idx_d   = 2'd0;
                state_d = S_RUN;
            end
            S_RUN: begin
                busy        = 1'b1;
                enable      = 1'b1;
                select_line = (idx_q != 2'd0);
                layer_no    = (idx_q == LAST_LAYER) ? LAST_LAYER : idx_q + 2'd1;
                if (idx_q == LAST_LAYER) state_d = S_DRAIN;
                else                     idx_d   = idx_q + 2'd1;
            end
            S_DRAIN: begin
                busy        = 1'b1;
                select_line = LAST_SEL;
                layer_no    = LAST_LAYER;
                capture     = 1'b1;
`ifdef NN_SEQ_ARGMAX_EN
                lane_d  = 3'd0;
                state_d = S_ARGMAX;
`else
                done_d  = 1'b1;
                state_d = S_IDLE;
`endif
            end
`ifdef NN_SEQ_ARGMAX_EN
            S_ARGMAX: begin
                busy        = 1'b1;
                select_line = LAST_SEL;
                layer_no    = LAST_LAYER;
                if (take) begin
                    max_d  = lane_val;
                    best_d = lane_q;
                end
                if (lane_q == 3'(LANES - 1)) begin
                    class_d = take ? lane_q : best_q;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    lane_d = lane_q + 3'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (abort) begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            capture = 1'b0;
`ifdef NN_SEQ_ARGMAX_EN
            class_d = class_q;
`endif
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= 2'd0;
            done_q   <= 1'b0;
            result_q <= '0;
`ifdef NN_SEQ_ARGMAX_EN
            lane_q  <= 3'd0;
            best_q  <= 3'd0;
            class_q <= 3'd0;
            max_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
            if (capture) result_q <= alu_output_data;
`ifdef NN_SEQ_ARGMAX_EN
            lane_q  <= lane_d;
            best_q  <= best_d;
            class_q <= class_d;
            max_q   <= max_d;
`endif
        end
    end

    assign done        = done_q;
    assign result_data = result_q;

endmodule
